alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_adder.sv | 25 ++
 rtl/alu.sv | 87 ++++++++
 tb/tb_alu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, flag bundle and helpers.
// Imported by the ALU top and its adder.
package alu_pkg;

    // Bit 2 inverts operand B and is also the adder carry-in.
    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_ZERO = 3'b011,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_RESET = '{
        zero:     1'b1,
        negative: 1'b0,
        carry:    1'b0,
        overflow: 1'b0
    };

    // Carry and overflow are only meaningful for plain ADD/SUB.
    function automatic logic is_arith(input alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_adder.sv
// N-bit adder with carry-in, shared by ADD, SUB and SLT.
// Reports carry-out and two's-complement signed overflow.
module alu_adder
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [N:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign sum    = w_full[N-1:0];
    assign cout   = w_full[N];

    // Same-sign operands producing an opposite-sign sum.
    assign ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU: logic ops, add/sub, signed SLT.
// Result and flags are captured in one register stage.
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] SrcA,
    input  logic [N-1:0] SrcB,
    input  logic [2:0]   ALUControl,
    output logic [N-1:0] ALUResult,
    output logic         Zero,
    output logic         Negative,
    output logic         Carry,
    output logic         Overflow
);

    alu_op_e    w_op;
    logic       w_cin;
    logic [N-1:0] w_bb;
    logic [N-1:0] w_sum;
    logic       w_cout;
    logic       w_ovf;
    logic [N-1:0] w_result;
    alu_flags_t w_flags;

    logic [N-1:0] r_result;
    alu_flags_t r_flags;

    assign w_op  = alu_op_e'(ALUControl);
    assign w_cin = ALUControl[2];
    assign w_bb  = w_cin ? ~SrcB : SrcB;

    alu_adder #(
        .N(N)
    ) u_adder (
        .a   (SrcA),
        .b   (w_bb),
        .cin (w_cin),
        .sum (w_sum),
        .cout(w_cout),
        .ovf (w_ovf)
    );

    always_comb begin
        w_result = '0;
        case (w_op)
            ALU_AND,
            ALU_ANDN: w_result = SrcA & w_bb;
            ALU_OR,
            ALU_ORN:  w_result = SrcA | w_bb;
            ALU_ADD,
            ALU_SUB:  w_result = w_sum;
            // Signed less-than: true sign of A-B is sign XOR overflow.
            ALU_SLT:  w_result = {{(N-1){1'b0}}, w_sum[N-1] ^ w_ovf};
            ALU_ZERO: w_result = '0;
            default:  w_result = '0;
        endcase
    end

    always_comb begin
        w_flags          = FLAGS_RESET;
        w_flags.zero     = (w_result == '0);
        w_flags.negative = w_result[N-1];
        w_flags.carry    = is_arith(w_op) & w_cout;
        w_flags.overflow = is_arith(w_op) & w_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= FLAGS_RESET;
        end else begin
            r_result <= w_result;
            r_flags  <= w_flags;
        end
    end

    assign ALUResult = r_result;
    assign Zero      = r_flags.zero;
    assign Negative  = r_flags.negative;
    assign Carry     = r_flags.carry;
    assign Overflow  = r_flags.overflow;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the registered ALU: expectations queued at drive
// time, compared one cycle later against the DUT outputs.
module tb_alu;

    localparam int N = 32;

    typedef struct {
        string       tag;
        logic [N-1:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } exp_t;

    typedef struct {
        string       tag;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]  ctl;
        logic [N-1:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [N-1:0] SrcA;
    logic [N-1:0] SrcB;
    logic [2:0]   ALUControl;
    logic [N-1:0] ALUResult;
    logic         Zero;
    logic         Negative;
    logic         Carry;
    logic         Overflow;

    int   n_total;
    int   n_bad;
    exp_t sb_q[$];
    bit   drive_done;

    alu #(
        .N(N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .ALUControl(ALUControl),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .Negative  (Negative),
        .Carry     (Carry),
        .Overflow  (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent reference: wide signed arithmetic, direct signed compare.
    function automatic exp_t model(input string tag, input logic [N-1:0] a,
                                   input logic [N-1:0] b,
                                   input logic [2:0] ctl);
        exp_t   e;
        logic [N:0] w;
        longint s;
        e.tag = tag;
        e.r = '0;
        e.c = 1'b0;
        e.v = 1'b0;
        case (ctl)
            3'b000: e.r = a & b;
            3'b001: e.r = a | b;
            3'b010: begin
                w = {1'b0, a} + {1'b0, b};
                e.r = w[N-1:0];
                e.c = w[N];
                s = longint'($signed(a)) + longint'($signed(b));
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b011: e.r = '0;
            3'b100: e.r = a & ~b;
            3'b101: e.r = a | ~b;
            3'b110: begin
                w = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.r = w[N-1:0];
                e.c = w[N];
                s = longint'($signed(a)) - longint'($signed(b));
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        e.z = (e.r == '0);
        e.n = e.r[N-1];
        return e;
    endfunction

    task automatic drive(input string tag, input logic rst,
                         input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2:0] ctl, input exp_t e);
        @(negedge clk);
        reset      = rst;
        SrcA       = a;
        SrcB       = b;
        ALUControl = ctl;
        e.tag      = tag;
        sb_q.push_back(e);
    endtask

    task automatic drive_rst(input string tag, input logic [N-1:0] a,
                             input logic [N-1:0] b, input logic [2:0] ctl);
        exp_t e;
        e.tag = tag;
        e.r = '0;
        e.z = 1'b1;
        e.n = 1'b0;
        e.c = 1'b0;
        e.v = 1'b0;
        drive(tag, 1'b1, a, b, ctl, e);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, ".res"}, 64'(ALUResult), 64'(e.r));
            chk({e.tag, ".z"}, 64'(Zero), 64'(e.z));
            chk({e.tag, ".n"}, 64'(Negative), 64'(e.n));
            chk({e.tag, ".c"}, 64'(Carry), 64'(e.c));
            chk({e.tag, ".v"}, 64'(Overflow), 64'(e.v));
        end
    end

    vec_t vecs[$];

    initial begin
        exp_t e;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0] c;
        n_total = 0;
        n_bad = 0;
        drive_done = 1'b0;
        reset = 1'b1;
        SrcA = '0;
        SrcB = '0;
        ALUControl = 3'b000;

        vecs = '{
            '{"and",    32'd10, 32'd5, 3'b000, 32'd0,        1, 0, 0, 0},
            '{"or",     32'd10, 32'd5, 3'b001, 32'd15,       0, 0, 0, 0},
            '{"andn",   32'd10, 32'd5, 3'b100, 32'd10,       0, 0, 0, 0},
            '{"orn",    32'd10, 32'd5, 3'b101, 32'hFFFFFFFA, 0, 1, 0, 0},
            '{"add1",   32'd10, 32'd5, 3'b010, 32'd15,       0, 0, 0, 0},
            '{"sub1",   32'd10, 32'd5, 3'b110, 32'd5,        0, 0, 1, 0},
            '{"add2",   32'd5, 32'd10, 3'b010, 32'd15,       0, 0, 0, 0},
            '{"sub2",   32'd5, 32'd10, 3'b110, 32'hFFFFFFFB, 0, 1, 0, 0},
            '{"addneg", 32'hFFFFFFFB, 32'hFFFFFFFB, 3'b010,
              32'hFFFFFFF6, 0, 1, 1, 0},
            '{"subneg", 32'hFFFFFFFB, 32'hFFFFFFFB, 3'b110,
              32'd0, 1, 0, 1, 0},
            '{"addovf", 32'h7FFFFFFF, 32'd1, 3'b010,
              32'h80000000, 0, 1, 0, 1},
            '{"slt1",   32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 0, 0, 0, 0},
            '{"slt2",   32'd1, 32'hFFFFFFFF, 3'b111, 32'd0, 1, 0, 0, 0},
            '{"slt3",   32'h80000000, 32'd1, 3'b111, 32'd1, 0, 0, 0, 0},
            '{"zero",   32'd10, 32'd5, 3'b011, 32'd0,        1, 0, 0, 0}
        };

        drive_rst("rst0", 32'd10, 32'd5, 3'b001);
        drive_rst("rst1", 32'hFFFFFFFF, 32'd1, 3'b010);

        foreach (vecs[i]) begin
            e.r = vecs[i].r;
            e.z = vecs[i].z;
            e.n = vecs[i].n;
            e.c = vecs[i].c;
            e.v = vecs[i].v;
            drive(vecs[i].tag, 1'b0, vecs[i].a, vecs[i].b,
                  vecs[i].ctl, e);
        end

        for (int i = 0; i < 4; i++) begin
            a = 32'(i * 100 + 7);
            b = 32'(i + 1);
            drive($sformatf("addrun%0d", i), 1'b0, a, b, 3'b010,
                  model("", a, b, 3'b010));
        end
        drive_rst("midrst", 32'd50, 32'd50, 3'b010);
        for (int i = 0; i < 3; i++) begin
            a = 32'hFFFFFFF0 + 32'(i);
            b = 32'd20;
            drive($sformatf("resume%0d", i), 1'b0, a, b, 3'b010,
                  model("", a, b, 3'b010));
        end

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = (i % 5 == 0) ? a : $urandom;
            c = 3'($urandom_range(0, 7));
            drive($sformatf("rnd%0d", i), 1'b0, a, b, c,
                  model("", a, b, c));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        drive_done = 1'b1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        if (!drive_done) begin
            $display("FAIL timeout got=running exp=finished");
            $fatal(1, "timeout");
        end
    end

endmodule
